// File: rtl/alu_issue_ctrl_if.sv
// Host command, ALU trig/vld/work and response signals of the ALU issue controller.
// master: the issue controller itself; slave: the host and ALU environment around it.
// DEPTH only sizes fifo_count and must match the controller's DEPTH.
interface alu_issue_ctrl_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_opcode;
    logic [31:0]   cmd_data1;
    logic [31:0]   cmd_data2;
    logic [31:0]   alu_data1;
    logic [31:0]   alu_data2;
    logic [1:0]    alu_opcode;
    logic          alu_trig;
    logic [31:0]   alu_result;
    logic          alu_vld;
    logic          alu_work;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic [1:0]    rsp_opcode;
    logic          rsp_timeout;
    logic [CW-1:0] fifo_count;
    logic          busy;

    modport master (
        input  cmd_valid, cmd_opcode, cmd_data1, cmd_data2,
        input  alu_result, alu_vld, alu_work, rsp_ready,
        output cmd_ready, alu_data1, alu_data2, alu_opcode, alu_trig,
        output rsp_valid, rsp_data, rsp_opcode, rsp_timeout, fifo_count, busy
    );

    modport slave (
        output cmd_valid, cmd_opcode, cmd_data1, cmd_data2,
        output alu_result, alu_vld, alu_work, rsp_ready,
        input  cmd_ready, alu_data1, alu_data2, alu_opcode, alu_trig,
        input  rsp_valid, rsp_data, rsp_opcode, rsp_timeout, fifo_count, busy
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Purpose: queue host ALU commands and issue them one at a time over trig/vld/work.
// Latency: accept in T -> alu_trig in T+2 (empty queue, idle ALU); alu_vld in V -> rsp_valid in V+1.
// Backpressure: cmd_ready low while the queue is full; rsp_* held until rsp_ready, nothing issues meanwhile.

// Small synchronous FIFO; count-based full/empty so all DEPTH entries are usable.
module alu_issue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage needs no reset: an empty count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); simultaneous push/pop keeps count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[rd_ptr];
endmodule

module alu_issue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input logic              sys_clk,
    input logic              sys_rst,
    alu_issue_ctrl_if.master bus
);
    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [31:0] TO_DATA = 32'h7FC0_0000;

    typedef struct packed {
        logic [1:0]  opcode;
        logic [31:0] data1;
        logic [31:0] data2;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state;
    logic [15:0]   tmo_cnt;
    cmd_t          push_cmd;
    cmd_t          head_cmd;
    logic          push;
    logic          pop;
    logic          cmd_ready;
    logic [CW-1:0] count;

    logic [31:0]   alu_data1_q;
    logic [31:0]   alu_data2_q;
    logic [1:0]    alu_opcode_q;
    logic          alu_trig_q;
    logic          rsp_valid_q;
    logic [31:0]   rsp_data_q;
    logic [1:0]    rsp_opcode_q;
    logic          rsp_timeout_q;

    // Ready depends only on occupancy, so a pop in the same cycle cannot open a full queue.
    assign cmd_ready = (count != CW'(DEPTH));
    assign push      = bus.cmd_valid && cmd_ready;
    assign push_cmd  = {bus.cmd_opcode, bus.cmd_data1, bus.cmd_data2};
    assign pop       = (state == IDLE) && (count != '0) && !bus.alu_work;

    alu_issue_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (push),
        .pop   (pop),
        .din   (push_cmd),
        .dout  (head_cmd),
        .count (count)
    );

    // Issue FSM: one command in flight, trig pulses in ISSUE, result or timeout parked in RESP.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            alu_data1_q   <= '0;
            alu_data2_q   <= '0;
            alu_opcode_q  <= '0;
            alu_trig_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_opcode_q  <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        alu_data1_q  <= head_cmd.data1;
                        alu_data2_q  <= head_cmd.data2;
                        alu_opcode_q <= head_cmd.opcode;
                        alu_trig_q   <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    alu_trig_q <= 1'b0;
                    tmo_cnt    <= '0;
                    if (bus.alu_vld) begin
                        rsp_data_q    <= bus.alu_result;
                        rsp_opcode_q  <= alu_opcode_q;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state         <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // A result arriving on the expiry cycle still wins over the timeout.
                    if (bus.alu_vld) begin
                        rsp_data_q    <= bus.alu_result;
                        rsp_opcode_q  <= alu_opcode_q;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state         <= RESP;
                    end else if (tmo_cnt == TO_LAST) begin
                        rsp_data_q    <= TO_DATA;
                        rsp_opcode_q  <= alu_opcode_q;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state         <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.fifo_count  = count;
    assign bus.busy        = (state != IDLE) || (count != '0);
    assign bus.alu_data1   = alu_data1_q;
    assign bus.alu_data2   = alu_data2_q;
    assign bus.alu_opcode  = alu_opcode_q;
    assign bus.alu_trig    = alu_trig_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_opcode  = rsp_opcode_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed commands, a scripted ALU model and a response scoreboard.
// Stimulus and checks run at the falling edge; the DUT only changes on the rising edge.
module tb_alu_issue_ctrl;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    alu_issue_ctrl_if #(.DEPTH(DEPTH)) bus ();

    alu_issue_ctrl #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  opcode;
        logic        tmo;
    } rsp_t;

    rsp_t        exp_q [$];
    int          dly_q [$];
    logic [31:0] res_q [$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int trig_cnt    = 0;
    int trig_cyc    = 0;
    int rsp_cnt     = 0;
    int rsp_cyc     = 0;

    always @(negedge sys_clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts trig pulses and pops the scoreboard on every accepted response.
    initial begin
        rsp_t e;
        forever begin
            @(negedge sys_clk);
            #1;
            if (bus.alu_trig) begin
                trig_cnt++;
                trig_cyc = cyc;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_cnt++;
                rsp_cyc = cyc;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_rsp: got data=%h op=%0d tmo=%0d expected no response",
                             bus.rsp_data, bus.rsp_opcode, bus.rsp_timeout);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.rsp_data, bus.rsp_opcode, bus.rsp_timeout} !== e) begin
                        miscompares++;
                        $display("FAIL rsp: got data=%h op=%0d tmo=%0d expected data=%h op=%0d tmo=%0d",
                                 bus.rsp_data, bus.rsp_opcode, bus.rsp_timeout, e.data, e.opcode, e.tmo);
                    end
                end
            end
        end
    end

    // ALU model: after each trig, raise alu_vld for one cycle 'delay' cycles later (-1 = never).
    initial begin
        int          d;
        logic [31:0] r;
        bus.alu_vld    = 1'b0;
        bus.alu_result = '0;
        forever begin
            @(negedge sys_clk);
            #1;
            if (bus.alu_trig) begin
                if (dly_q.size() > 0) begin
                    d = dly_q.pop_front();
                    r = res_q.pop_front();
                end else begin
                    d = -1;
                    r = '0;
                end
                if (d >= 0) begin
                    repeat (d) @(negedge sys_clk);
                    bus.alu_result = r;
                    bus.alu_vld    = 1'b1;
                    @(negedge sys_clk);
                    bus.alu_vld    = 1'b0;
                end
            end
        end
    end

    // Present one command for a cycle; on acceptance queue the ALU behaviour and expected response.
    task automatic send(input logic [1:0] op, input logic [31:0] d1, input logic [31:0] d2,
                        input int dly, input logic [31:0] res, input rsp_t exp, output logic acc);
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_data1  = d1;
        bus.cmd_data2  = d2;
        acc = bus.cmd_ready;
        @(negedge sys_clk);
        bus.cmd_valid = 1'b0;
        if (acc) begin
            dly_q.push_back(dly);
            res_q.push_back(res);
            exp_q.push_back(exp);
        end
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !bus.busy) break;
            @(negedge sys_clk);
        end
        check(name, (exp_q.size() == 0 && !bus.busy), 1);
    endtask

    initial begin
        logic acc;
        int   tc;
        int   rc;
        int   dly2 [4] = '{0, 1, 3, 2};

        bus.cmd_valid  = 1'b0;
        bus.cmd_opcode = '0;
        bus.cmd_data1  = '0;
        bus.cmd_data2  = '0;
        bus.alu_work   = 1'b0;
        bus.rsp_ready  = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // Reset state
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_outputs", {bus.alu_data1, bus.alu_data2, bus.alu_opcode, bus.alu_trig, bus.rsp_valid,
                              bus.rsp_data, bus.rsp_opcode, bus.rsp_timeout, bus.fifo_count, bus.busy}, 0);

        // 1: single command, vld 5 cycles after trig
        tc = trig_cnt;
        send(2'd0, 32'h3F80_0000, 32'h4000_0000, 5, 32'h4040_0000, '{32'h4040_0000, 2'd0, 1'b0}, acc);
        check("t1_accept", acc, 1);
        check("t1_trig_T1", {bus.alu_trig, bus.fifo_count}, {1'b0, 3'd1});
        @(negedge sys_clk);
        check("t1_trig_T2", bus.alu_trig, 1);
        check("t1_operands", {bus.alu_opcode, bus.alu_data1, bus.alu_data2},
              {2'd0, 32'h3F80_0000, 32'h4000_0000});
        drain("t1_drain", 40);
        check("t1_trig_count", trig_cnt - tc, 1);
        check("t1_rsp_latency", rsp_cyc - trig_cyc, 6);

        // 2: ALU busy, 5 pushes -> 4 accepted, then full+pop+push cycle, then in-order drain
        bus.alu_work = 1'b1;
        tc = trig_cnt;
        for (int i = 0; i < 5; i++) begin
            send(2'(i), 32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i), dly2[i % 4],
                 32'hA000_0000 + 32'(i), '{32'hA000_0000 + 32'(i), 2'(i), 1'b0}, acc);
            check("t2_accept", acc, (i < 4));
        end
        check("t2_full", {bus.fifo_count, bus.cmd_ready}, {3'd4, 1'b0});
        repeat (3) @(negedge sys_clk);
        check("t2_no_trig", {trig_cnt - tc, 31'(bus.busy)}, {32'd0, 31'd1});
        bus.alu_work   = 1'b0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = 2'd0;
        bus.cmd_data1  = 32'h0000_0055;
        bus.cmd_data2  = 32'h0000_0055;
        check("t2_full_pop_ready", bus.cmd_ready, 0);
        @(negedge sys_clk);
        bus.cmd_valid = 1'b0;
        check("t2_count_after_pop", bus.fifo_count, 3);
        drain("t2_drain", 200);
        check("t2_trig_count", trig_cnt - tc, 4);

        // 3: timeout after TIMEOUT wait cycles, then a normal command
        send(2'd1, 32'h3F80_0000, 32'h3F80_0000, -1, '0, '{32'h7FC0_0000, 2'd1, 1'b1}, acc);
        drain("t3_drain_tmo", 60);
        check("t3_tmo_latency", rsp_cyc - trig_cyc, 9);
        send(2'd2, 32'h4000_0000, 32'h4000_0000, 2, 32'h4080_0000, '{32'h4080_0000, 2'd2, 1'b0}, acc);
        drain("t3_drain_next", 60);
        check("t3_next_latency", rsp_cyc - trig_cyc, 3);

        // 4: response held 10 cycles with a command queued behind it
        bus.rsp_ready = 1'b0;
        send(2'd3, 32'h4000_0000, 32'hC000_0000, 1, 32'hC000_0000, '{32'hC000_0000, 2'd3, 1'b0}, acc);
        send(2'd0, 32'h4100_0000, 32'h4100_0000, 1, 32'h4200_0000, '{32'h4200_0000, 2'd0, 1'b0}, acc);
        for (int i = 0; i < 20 && !bus.rsp_valid; i++) @(negedge sys_clk);
        tc = trig_cnt;
        for (int i = 0; i < 10; i++) begin
            check("t4_hold", {bus.rsp_valid, bus.rsp_data, bus.rsp_opcode, bus.rsp_timeout},
                  {1'b1, 32'hC000_0000, 2'd3, 1'b0});
            @(negedge sys_clk);
        end
        check("t4_no_issue", {trig_cnt - tc, 29'(bus.fifo_count)}, {32'd0, 29'd1});
        bus.rsp_ready = 1'b1;
        drain("t4_drain", 60);
        check("t4_trig_count", trig_cnt - tc, 1);

        // 5: reset during WAIT with two queued; late alu_vld must not respond
        tc = trig_cnt;
        send(2'd1, 32'h1111_1111, 32'h2222_2222, 6, 32'hDEAD_BEEF, '{32'hDEAD_BEEF, 2'd1, 1'b0}, acc);
        send(2'd2, 32'h3333_3333, 32'h4444_4444, 1, 32'h5555_5555, '{32'h5555_5555, 2'd2, 1'b0}, acc);
        send(2'd3, 32'h6666_6666, 32'h7777_7777, 1, 32'h8888_8888, '{32'h8888_8888, 2'd3, 1'b0}, acc);
        repeat (2) @(negedge sys_clk);
        check("t5_pre_rst", {trig_cnt - tc, 29'(bus.fifo_count)}, {32'd1, 29'd2});
        sys_rst = 1'b1;
        exp_q.delete();
        dly_q.delete();
        res_q.delete();
        @(negedge sys_clk);
        check("t5_rst_outputs", {bus.alu_data1, bus.alu_data2, bus.alu_opcode, bus.alu_trig, bus.rsp_valid,
                                 bus.rsp_data, bus.rsp_opcode, bus.rsp_timeout, bus.fifo_count, bus.busy}, 0);
        check("t5_rst_cmd_ready", bus.cmd_ready, 1);
        sys_rst = 1'b0;
        rc = rsp_cnt;
        repeat (12) @(negedge sys_clk);
        check("t5_no_late_rsp", {rsp_cnt - rc, trig_cnt - tc, 31'(bus.busy)}, {32'd0, 32'd1, 31'd0});

        // 6: vld on the expiry cycle wins; one cycle later the timeout wins
        send(2'd2, 32'h4040_0000, 32'h3F80_0000, 8, 32'h4080_0000, '{32'h4080_0000, 2'd2, 1'b0}, acc);
        drain("t6_drain_edge", 60);
        check("t6_edge_latency", rsp_cyc - trig_cyc, 9);
        send(2'd3, 32'h4040_0000, 32'h3F80_0000, 9, 32'h1234_5678, '{32'h7FC0_0000, 2'd3, 1'b1}, acc);
        drain("t6_drain_late", 60);
        check("t6_late_latency", rsp_cyc - trig_cyc, 9);
        repeat (3) @(negedge sys_clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run expected completion before 200000 ns");
        $fatal(1, "watchdog expired");
    end
endmodule
